// File: rtl/proc_ctrl_fsm.sv
// Control unit for the 9-bit simple processor: T0..T3 step sequencer decoding bus strobes and loads.
// Optional feature macro PROC_CTRL_MVNZ_EN adds the g_nz input and the mvnz (op 100) instruction.
module proc_ctrl_fsm #(
    parameter int IR_W = 9,
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
`ifdef PROC_CTRL_MVNZ_EN
    input  logic            g_nz,
`endif
    output logic [NREG-1:0] r_out,
    output logic            din_out,
    output logic            g_out,
    output logic [NREG-1:0] r_in,
    output logic            ir_in,
    output logic            a_in,
    output logic            g_in,
    output logic            add_sub,
    output logic            done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      w_op;
    logic [NREG-1:0] w_x_oh;
    logic [NREG-1:0] w_y_oh;
    logic            w_is_alu;

    assign w_op     = ir[8:6];
    assign w_x_oh   = {{(NREG-1){1'b0}}, 1'b1} << ir[5:3];
    assign w_y_oh   = {{(NREG-1){1'b0}}, 1'b1} << ir[2:0];
    assign w_is_alu = (w_op == 3'b010) || (w_op == 3'b011);

    // Step counter; only add/sub continue past T1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= T0;
        end else begin
            case (r_state)
                T0:      r_state <= run ? T1 : T0;
                T1:      r_state <= w_is_alu ? T2 : T0;
                T2:      r_state <= T3;
                T3:      r_state <= T0;
                default: r_state <= T0;
            endcase
        end
    end

    // Output decode of state and IR; everything is held at 0 while reset is low.
    always_comb begin
        r_out   = {NREG{1'b0}};
        din_out = 1'b0;
        g_out   = 1'b0;
        r_in    = {NREG{1'b0}};
        ir_in   = 1'b0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        add_sub = 1'b0;
        done    = 1'b0;
        if (resetn) begin
            case (r_state)
                T0: begin
                    ir_in = run;
                end
                T1: begin
                    case (w_op)
                        3'b000: begin
                            r_out = w_y_oh;
                            r_in  = w_x_oh;
                            done  = 1'b1;
                        end
                        3'b001: begin
                            din_out = 1'b1;
                            r_in    = w_x_oh;
                            done    = 1'b1;
                        end
                        3'b010, 3'b011: begin
                            r_out = w_x_oh;
                            a_in  = 1'b1;
                        end
`ifdef PROC_CTRL_MVNZ_EN
                        // Source is strobed regardless of g_nz so the bus never floats.
                        3'b100: begin
                            r_out = w_y_oh;
                            r_in  = g_nz ? w_x_oh : {NREG{1'b0}};
                            done  = 1'b1;
                        end
`endif
                        default: begin
                            done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    r_out   = w_y_oh;
                    g_in    = 1'b1;
                    add_sub = w_op[0];
                end
                T3: begin
                    g_out = 1'b1;
                    r_in  = w_x_oh;
                    done  = 1'b1;
                end
                default: begin
                    done = 1'b0;
                end
            endcase
        end else begin
            done = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: driver pushes per-cycle expected outputs, monitor pops on negedge.
module tb_proc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       resetn;
    logic       run;
    logic [8:0] ir;
`ifdef PROC_CTRL_MVNZ_EN
    logic       g_nz;
`endif
    logic [7:0] r_out;
    logic       din_out;
    logic       g_out;
    logic [7:0] r_in;
    logic       ir_in;
    logic       a_in;
    logic       g_in;
    logic       add_sub;
    logic       done;

    typedef struct {
        string       name;
        logic [22:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    proc_ctrl_fsm dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .ir      (ir),
`ifdef PROC_CTRL_MVNZ_EN
        .g_nz    (g_nz),
`endif
        .r_out   (r_out),
        .din_out (din_out),
        .g_out   (g_out),
        .r_in    (r_in),
        .ir_in   (ir_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .add_sub (add_sub),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Packs {r_out, din_out, g_out, r_in, ir_in, a_in, g_in, add_sub, done}
    function automatic logic [22:0] ex(input logic [7:0] ro, input logic di, input logic go,
                                       input logic [7:0] ri, input logic iri, input logic ai,
                                       input logic gi, input logic asb, input logic dn);
        return {ro, di, go, ri, iri, ai, gi, asb, dn};
    endfunction

    task automatic cyc(input string nm, input logic rn, input logic rv, input logic [8:0] iv,
                       input logic [22:0] e);
        exp_t t;
        resetn = rn;
        run    = rv;
        ir     = iv;
        t.name = nm;
        t.vec  = e;
        sb.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT output bundle against the oldest expected entry
    always @(negedge clk) begin
        exp_t        t;
        logic [22:0] act;
        if (sb.size() > 0) begin
            t   = sb.pop_front();
            act = {r_out, din_out, g_out, r_in, ir_in, a_in, g_in, add_sub, done};
            n_total++;
            if (act === t.vec) n_pass++;
            else $display("FAIL %s: got %h expected %h", t.name, act, t.vec);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [22:0] z;
        logic [22:0] t0;
        z  = ex(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        t0 = ex(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b0;
        run    = 1'b1;
        ir     = 9'o000;
`ifdef PROC_CTRL_MVNZ_EN
        g_nz   = 1'b0;
`endif
        @(posedge clk);
        #1;

        cyc("reset0", 1'b0, 1'b1, 9'o000, z);
        cyc("reset1", 1'b0, 1'b1, 9'o000, z);
        cyc("t0_after_reset", 1'b1, 1'b1, 9'o000, t0);
        // mvi R0,#5 with run still high: run is ignored in T1
        cyc("mvi_t1", 1'b1, 1'b1, 9'o100, ex(8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc("mv_t0", 1'b1, 1'b1, 9'o100, t0);
        cyc("mv_t1", 1'b1, 1'b0, 9'o010, ex(8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc("idle_t0", 1'b1, 1'b0, 9'o010, z);

        cyc("add_t0", 1'b1, 1'b1, 9'o221, t0);
        cyc("add_t1", 1'b1, 1'b0, 9'o221, ex(8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("add_t2", 1'b1, 1'b0, 9'o221, ex(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("add_t3", 1'b1, 1'b0, 9'o221, ex(8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        cyc("sub_t0", 1'b1, 1'b1, 9'o333, t0);
        cyc("sub_t1", 1'b1, 1'b1, 9'o333, ex(8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("sub_t2", 1'b1, 1'b1, 9'o333, ex(8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        cyc("sub_t3", 1'b1, 1'b1, 9'o333, ex(8'h00, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        // Reset during T2 abandons the add; the next cycle must be an idle T0
        cyc("abort_t0", 1'b1, 1'b1, 9'o221, t0);
        cyc("abort_t1", 1'b1, 1'b0, 9'o221, ex(8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("abort_rst", 1'b0, 1'b0, 9'o221, z);
        cyc("abort_idle", 1'b1, 1'b0, 9'o221, z);
        cyc("readd_t0", 1'b1, 1'b1, 9'o221, t0);
        cyc("readd_t1", 1'b1, 1'b0, 9'o221, ex(8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("readd_t2", 1'b1, 1'b0, 9'o221, ex(8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("readd_t3", 1'b1, 1'b0, 9'o221, ex(8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        cyc("nop7_t0", 1'b1, 1'b1, 9'o700, t0);
        cyc("nop7_t1", 1'b1, 1'b0, 9'o700, ex(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc("nop7_after", 1'b1, 1'b0, 9'o700, z);

`ifdef PROC_CTRL_MVNZ_EN
        g_nz = 1'b0;
        cyc("mvnz0_t0", 1'b1, 1'b1, 9'o412, t0);
        cyc("mvnz0_t1", 1'b1, 1'b0, 9'o412, ex(8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        g_nz = 1'b1;
        cyc("mvnz1_t0", 1'b1, 1'b1, 9'o412, t0);
        cyc("mvnz1_t1", 1'b1, 1'b0, 9'o412, ex(8'h04, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`else
        cyc("op4_t0", 1'b1, 1'b1, 9'o412, t0);
        cyc("op4_nop_t1", 1'b1, 1'b0, 9'o412, ex(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
        cyc("final_idle", 1'b1, 1'b0, 9'o000, z);

        @(posedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
